// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the bit-sequence detectors.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } seq_state_e;

    localparam logic IDLE_BIT_DEFAULT = 1'b1;

endpackage

// File: rtl/sequence_pattern_generator_if.sv
// Request/stream bundle between a stimulus controller and the pattern generator.
interface sequence_pattern_generator_if #(
    parameter int unsigned PAT_W = 3,
    parameter int unsigned CNT_W = 10,
    parameter int unsigned GAP_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent_count;

    modport master (
        output start, abort, pattern, reps, gap,
        input  x, x_valid, busy, done, sent_count
    );

    modport slave (
        input  start, abort, pattern, reps, gap,
        output x, x_valid, busy, done, sent_count
    );
endinterface

// File: rtl/seq_piso.sv
// Parallel-in serial-out register, MSB first; the index wraps to the top on the last bit.
module seq_piso #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout,
    output logic         last
);
    localparam int unsigned   IW  = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] TOP = IW'(W - 1);

    logic [W-1:0]  data_q;
    logic [IW-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            idx_q  <= TOP;
        end else if (load) begin
            data_q <= din;
            idx_q  <= TOP;
        end else if (shift) begin
            // wrapping here lets back-to-back repetitions start without a reload
            idx_q <= (idx_q == '0) ? TOP : idx_q - 1'b1;
        end
    end

    assign dout = data_q[idx_q];
    assign last = (idx_q == '0);

endmodule

// File: rtl/sequence_pattern_generator.sv
// Serial stimulus source: repeats a latched pattern MSB-first with idle gaps, counting completed patterns.
module sequence_pattern_generator
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W    = 3,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned GAP_W    = 4,
    parameter logic        IDLE_BIT = IDLE_BIT_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    sequence_pattern_generator_if.slave     bus
);
    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] rep_left_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [CNT_W-1:0] sent_count_q;

    logic load, shift, piso_bit, piso_last, accept;

    assign accept = bus.start && (bus.reps != '0);

    seq_piso #(.W(PAT_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (bus.pattern),
        .dout  (piso_bit),
        .last  (piso_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    state_d = SEND;
                    load    = 1'b1;
                end
                SEND: begin
                    shift = 1'b1;
                    if (piso_last) begin
                        if (rep_left_q == CNT_W'(1)) state_d = DONE;
                        else if (gap_q == '0)        state_d = SEND;
                        else                         state_d = GAP;
                    end
                end
                GAP:  if (gap_cnt_q == GAP_W'(1)) state_d = SEND;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_left_q   <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            sent_count_q <= '0;
        end else if (!bus.abort) begin
            unique case (state_q)
                IDLE: if (accept) begin
                    rep_left_q <= bus.reps;
                    gap_q      <= bus.gap;
                end
                SEND: if (piso_last) begin
                    sent_count_q <= sent_count_q + 1'b1;
                    rep_left_q   <= rep_left_q - 1'b1;
                    gap_cnt_q    <= gap_q;
                end
                GAP:  gap_cnt_q <= gap_cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.x          = (state_q == SEND) ? piso_bit : IDLE_BIT;
    assign bus.x_valid    = (state_q == SEND);
    assign bus.busy       = (state_q == SEND) || (state_q == GAP);
    assign bus.done       = (state_q == DONE);
    assign bus.sent_count = sent_count_q;

endmodule

// File: tb/tb_sequence_pattern_generator.sv
// Directed self-checking bench for sequence_pattern_generator.
module tb_sequence_pattern_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned exp_cnt = 0;

    sequence_pattern_generator_if #(.PAT_W(3), .CNT_W(10), .GAP_W(4)) bus ();

    sequence_pattern_generator #(
        .PAT_W(3), .CNT_W(10), .GAP_W(4), .IDLE_BIT(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [2:0] p, input int unsigned r, input int unsigned g);
        bus.pattern = p;
        bus.reps    = 10'(r);
        bus.gap     = 4'(g);
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.done), 1);
    endtask

    initial begin
        logic [7:0] ex_x, ex_v;
        logic [2:0] win;
        logic [2:0] p010;
        int unsigned hits;

        bus.start = 1'b0; bus.abort = 1'b0;
        bus.pattern = '0; bus.reps = '0; bus.gap = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_x", 32'(bus.x), 1);
        check("reset_valid", 32'(bus.x_valid), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_cnt", 32'(bus.sent_count), 0);

        // 1: reset held two cycles mid-SEND, then a start right after release
        go(3'b010, 3, 0);
        tick(); tick(); tick();
        check("t1_cnt_before", 32'(bus.sent_count), 1);
        rst = 1'b1;
        tick(); tick();
        check("t1_x", 32'(bus.x), 1);
        check("t1_valid", 32'(bus.x_valid), 0);
        check("t1_busy", 32'(bus.busy), 0);
        check("t1_cnt", 32'(bus.sent_count), 0);
        rst = 1'b0;
        tick();
        go(3'b100, 1, 0);
        check("t1_first_bit", 32'(bus.x), 1);
        check("t1_first_valid", 32'(bus.x_valid), 1);
        exp_cnt = 1;
        wait_done("t1_done", 10);
        check("t1_cnt_after", 32'(bus.sent_count), exp_cnt);
        tick();

        // 2: single 010
        go(3'b010, 1, 0);
        check("t2_b0", {31'd0, bus.x_valid} * 2 + 32'(bus.x), 2);
        tick();
        check("t2_b1", {31'd0, bus.x_valid} * 2 + 32'(bus.x), 3);
        tick();
        check("t2_b2", {31'd0, bus.x_valid} * 2 + 32'(bus.x), 2);
        tick();
        exp_cnt++;
        check("t2_done", 32'(bus.done), 1);
        check("t2_busy", 32'(bus.busy), 0);
        check("t2_cnt", 32'(bus.sent_count), exp_cnt);
        tick();
        check("t2_done_width", 32'(bus.done), 0);

        // 3: three back-to-back 010s into an overlapping 010 detector model
        p010 = 3'b010;
        win = '0;
        hits = 0;
        go(3'b010, 3, 0);
        for (int unsigned i = 0; i < 9; i++) begin
            check("t3_valid", 32'(bus.x_valid), 1);
            check("t3_bit", 32'(bus.x), 32'(p010[2 - (i % 3)]));
            win = {win[1:0], bus.x};
            if (i >= 2 && win == 3'b010) hits++;
            tick();
        end
        exp_cnt += 3;
        check("t3_done", 32'(bus.done), 1);
        check("t3_det", hits, 3);
        check("t3_cnt", 32'(bus.sent_count), exp_cnt);
        tick();

        // 4: 110 twice with a two-cycle gap
        ex_x = 8'b1101_1110;
        ex_v = 8'b1110_0111;
        go(3'b110, 2, 2);
        for (int unsigned i = 0; i < 8; i++) begin
            check("t4_x", 32'(bus.x), 32'(ex_x[7 - i]));
            check("t4_valid", 32'(bus.x_valid), 32'(ex_v[7 - i]));
            check("t4_busy", 32'(bus.busy), 1);
            tick();
        end
        exp_cnt += 2;
        check("t4_done", 32'(bus.done), 1);
        check("t4_busy_end", 32'(bus.busy), 0);
        tick();

        // 5: reps=0 ignored; start mid-run ignored
        go(3'b111, 0, 0);
        check("t5_busy", 32'(bus.busy), 0);
        tick();
        check("t5_done", 32'(bus.done), 0);
        go(3'b010, 1, 0);
        bus.pattern = 3'b111; bus.reps = 10'd5; bus.gap = 4'd3; bus.start = 1'b1;
        check("t5_b0", 32'(bus.x), 0);
        tick();
        check("t5_b1", 32'(bus.x), 1);
        tick();
        check("t5_b2", 32'(bus.x), 0);
        tick();
        check("t5_done_pulse", 32'(bus.done), 1);
        tick();
        bus.start = 1'b0;
        exp_cnt++;
        check("t5_cnt", 32'(bus.sent_count), exp_cnt);
        check("t5_idle", 32'(bus.busy), 0);

        // 6: abort on 2nd bit of rep 2
        go(3'b010, 3, 0);
        tick(); tick(); tick(); tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        exp_cnt++;
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_done", 32'(bus.done), 0);
        check("t6_cnt", 32'(bus.sent_count), exp_cnt);
        tick();
        check("t6_no_done", 32'(bus.done), 0);

        // sent_count wrap from 1023 to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        go(3'b101, 1023, 0);
        wait_done("wrap_done1", 3200);
        check("wrap_1023", 32'(bus.sent_count), 1023);
        tick();
        go(3'b101, 1, 0);
        wait_done("wrap_done2", 10);
        check("wrap_zero", 32'(bus.sent_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
